// File: rtl/result_collector_pkg.sv
// Shared width helpers for the result collector slice.
package result_collector_pkg;

  localparam int unsigned DefaultNumTags    = 32'd8;
  localparam int unsigned DefaultBufferDepth = 32'd2;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/result_collector_checker.sv
// Protocol checker for the result collector ports.
module result_collector_checker #(
  parameter int unsigned IidWidth    = 32'd6,
  parameter int unsigned WidWidth    = 32'd3,
  parameter int unsigned TagWidth    = 32'd3,
  parameter int unsigned RegIdxWidth = 32'd8,
  parameter int unsigned WarpWidth   = 32'd4,
  parameter int unsigned DataWidth   = 32'd128,
  parameter int unsigned OccWidth    = 32'd2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic                   eu_to_rc_valid_i,
  input logic                   rc_to_eu_ready_o,
  input logic [IidWidth-1:0]    eu_to_rc_tag_i,
  input logic [RegIdxWidth-1:0] eu_to_rc_dst_i,
  input logic [WarpWidth-1:0]   eu_to_rc_act_mask_i,
  input logic [DataWidth-1:0]   eu_to_rc_data_i,
  input logic                   rc_to_rf_valid_o,
  input logic                   rf_to_rc_ready_i,
  input logic [WidWidth-1:0]    rc_to_rf_wid_o,
  input logic [RegIdxWidth-1:0] rc_to_rf_dst_o,
  input logic [WarpWidth-1:0]   rc_to_rf_mask_o,
  input logic [DataWidth-1:0]   rc_to_rf_data_o,
  input logic                   rc_to_wb_valid_o,
  input logic [OccWidth-1:0]    rc_occupancy_o
);

  rf_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rc_to_rf_valid_o && !rf_to_rc_ready_i) |=> (rc_to_rf_valid_o &&
      $stable({rc_to_rf_wid_o, rc_to_rf_dst_o, rc_to_rf_mask_o, rc_to_rf_data_o})));

  wb_not_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rc_to_wb_valid_o |-> (rc_occupancy_o != OccWidth'(0)));

  eu_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (eu_to_rc_valid_i && !rc_to_eu_ready_o) |=> (eu_to_rc_valid_i &&
      $stable({eu_to_rc_tag_i, eu_to_rc_dst_i, eu_to_rc_act_mask_i, eu_to_rc_data_i})));

endmodule

// File: rtl/result_collector_fifo.sv
// Generic FIFO without fall-through; depth need not be a power of two.
module result_collector_fifo
  import result_collector_pkg::*;
#(
  parameter int unsigned DataWidth = 32'd32,
  parameter int unsigned Depth     = DefaultBufferDepth,
  localparam int unsigned PtrWidth = idx_width(Depth),
  localparam int unsigned CntWidth = $clog2(Depth + 32'd1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 testmode_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  usage_o
);

  logic [DataWidth-1:0] mem_r [Depth];
  logic [PtrWidth-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CntWidth-1:0]  cnt_r, cnt_nxt_s;
  logic                 push_s, pop_s;
  logic                 unused_testmode_s;

  assign unused_testmode_s = testmode_i;

  // Handshake qualification and pointer/count next-state.
  always_comb begin
    full_o  = (cnt_r == CntWidth'(Depth));
    empty_o = (cnt_r == CntWidth'(0));
    push_s  = push_i && !full_o;
    pop_s   = pop_i && !empty_o;
    wr_ptr_nxt_s = (wr_ptr_r == PtrWidth'(Depth - 32'd1)) ? PtrWidth'(0) : wr_ptr_r + PtrWidth'(1);
    rd_ptr_nxt_s = (rd_ptr_r == PtrWidth'(Depth - 32'd1)) ? PtrWidth'(0) : rd_ptr_r + PtrWidth'(1);
    if (push_s && !pop_s) begin
      cnt_nxt_s = cnt_r + CntWidth'(1);
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = cnt_r - CntWidth'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pointer and fill-level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= PtrWidth'(0);
      rd_ptr_r <= PtrWidth'(0);
      cnt_r    <= CntWidth'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_nxt_s;
      if (pop_s)  rd_ptr_r <= rd_ptr_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= data_i;
  end

  assign data_o  = mem_r[rd_ptr_r];
  assign usage_o = cnt_r;

endmodule

// File: rtl/result_collector.sv
// Buffers execution-unit results and writes them back to the register file in order.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NumTags     = DefaultNumTags,
  parameter int unsigned RegWidth    = 32'd32,
  parameter int unsigned WarpWidth   = 32'd4,
  parameter int unsigned NumWarps    = 32'd8,
  parameter int unsigned RegIdxWidth = 32'd8,
  parameter int unsigned BufferDepth = DefaultBufferDepth,
  localparam int unsigned TagWidth   = $clog2(NumTags),
  localparam int unsigned WidWidth   = idx_width(NumWarps),
  localparam int unsigned IidWidth   = TagWidth + WidWidth,
  localparam int unsigned OccWidth   = $clog2(BufferDepth + 32'd1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            testmode_i,
  input  logic                            eu_to_rc_valid_i,
  output logic                            rc_to_eu_ready_o,
  input  logic [IidWidth-1:0]             eu_to_rc_tag_i,
  input  logic [RegIdxWidth-1:0]          eu_to_rc_dst_i,
  input  logic [WarpWidth-1:0]            eu_to_rc_act_mask_i,
  input  logic [RegWidth*WarpWidth-1:0]   eu_to_rc_data_i,
  output logic                            rc_to_rf_valid_o,
  input  logic                            rf_to_rc_ready_i,
  output logic [WidWidth-1:0]             rc_to_rf_wid_o,
  output logic [RegIdxWidth-1:0]          rc_to_rf_dst_o,
  output logic [WarpWidth-1:0]            rc_to_rf_mask_o,
  output logic [RegWidth*WarpWidth-1:0]   rc_to_rf_data_o,
  output logic                            rc_to_wb_valid_o,
  output logic [WidWidth-1:0]             rc_to_wb_wid_o,
  output logic [TagWidth-1:0]             rc_to_wb_tag_o,
  output logic [OccWidth-1:0]             rc_occupancy_o
);

  typedef struct packed {
    logic [IidWidth-1:0]           iid;
    logic [RegIdxWidth-1:0]        dst;
    logic [WarpWidth-1:0]          act_mask;
    logic [RegWidth*WarpWidth-1:0] data;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

  entry_t push_entry_s, head_entry_s;
  logic   fifo_full_s, fifo_empty_s, push_s, pop_s, head_active_s;

  // Input packing and acceptance; ready depends on stored state only.
  always_comb begin
    push_entry_s.iid      = eu_to_rc_tag_i;
    push_entry_s.dst      = eu_to_rc_dst_i;
    push_entry_s.act_mask = eu_to_rc_act_mask_i;
    push_entry_s.data     = eu_to_rc_data_i;
    rc_to_eu_ready_o      = !fifo_full_s;
    push_s                = eu_to_rc_valid_i && !fifo_full_s;
  end

  result_collector_fifo #(
    .DataWidth (EntryWidth),
    .Depth     (BufferDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (testmode_i),
    .push_i     (push_s),
    .data_i     (push_entry_s),
    .pop_i      (pop_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .data_o     (head_entry_s),
    .usage_o    (rc_occupancy_o)
  );

  // Head dispatch: masked-off entries retire without touching the register file.
  always_comb begin
    head_active_s    = !fifo_empty_s && (head_entry_s.act_mask != WarpWidth'(0));
    if (fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (head_entry_s.act_mask == WarpWidth'(0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = rf_to_rc_ready_i;
    end
    rc_to_rf_valid_o = head_active_s;
    rc_to_rf_wid_o   = head_entry_s.iid[WidWidth-1:0];
    rc_to_rf_dst_o   = head_entry_s.dst;
    rc_to_rf_mask_o  = head_entry_s.act_mask;
    rc_to_rf_data_o  = head_entry_s.data;
    rc_to_wb_valid_o = pop_s;
    rc_to_wb_wid_o   = head_entry_s.iid[WidWidth-1:0];
    rc_to_wb_tag_o   = head_entry_s.iid[IidWidth-1:WidWidth];
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench with a queue-based reference model of the result collector.
module tb_result_collector;

  localparam int DEPTH = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         testmode_i = 1'b0;
  logic         eu_valid = 1'b0;
  logic         eu_ready;
  logic [5:0]   eu_tag = 6'd0;
  logic [7:0]   eu_dst = 8'd0;
  logic [3:0]   eu_mask = 4'd0;
  logic [127:0] eu_data = 128'd0;
  logic         rf_valid;
  logic         rf_ready = 1'b0;
  logic [2:0]   rf_wid;
  logic [7:0]   rf_dst;
  logic [3:0]   rf_mask;
  logic [127:0] rf_data;
  logic         wb_valid;
  logic [2:0]   wb_wid;
  logic [2:0]   wb_tag;
  logic [1:0]   occ;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]   iid;
    logic [7:0]   dst;
    logic [3:0]   mask;
    logic [127:0] data;
  } ent_t;

  ent_t q[$];

  always #5 clk_i = ~clk_i;

  result_collector dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .testmode_i(testmode_i),
    .eu_to_rc_valid_i(eu_valid), .rc_to_eu_ready_o(eu_ready),
    .eu_to_rc_tag_i(eu_tag), .eu_to_rc_dst_i(eu_dst),
    .eu_to_rc_act_mask_i(eu_mask), .eu_to_rc_data_i(eu_data),
    .rc_to_rf_valid_o(rf_valid), .rf_to_rc_ready_i(rf_ready),
    .rc_to_rf_wid_o(rf_wid), .rc_to_rf_dst_o(rf_dst),
    .rc_to_rf_mask_o(rf_mask), .rc_to_rf_data_o(rf_data),
    .rc_to_wb_valid_o(wb_valid), .rc_to_wb_wid_o(wb_wid),
    .rc_to_wb_tag_o(wb_tag), .rc_occupancy_o(occ)
  );

  result_collector_checker u_chk (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .eu_to_rc_valid_i(eu_valid), .rc_to_eu_ready_o(eu_ready),
    .eu_to_rc_tag_i(eu_tag), .eu_to_rc_dst_i(eu_dst),
    .eu_to_rc_act_mask_i(eu_mask), .eu_to_rc_data_i(eu_data),
    .rc_to_rf_valid_o(rf_valid), .rf_to_rc_ready_i(rf_ready),
    .rc_to_rf_wid_o(rf_wid), .rc_to_rf_dst_o(rf_dst),
    .rc_to_rf_mask_o(rf_mask), .rc_to_rf_data_o(rf_data),
    .rc_to_wb_valid_o(wb_valid), .rc_occupancy_o(occ)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue; the head retires when its mask is empty or the RF accepts.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
    end else begin
      automatic bit   do_pop = (q.size() > 0) && ((q[0].mask == 4'd0) || rf_ready);
      automatic bit   do_acc = eu_valid && (q.size() < DEPTH);
      automatic ent_t e;
      e.iid = eu_tag; e.dst = eu_dst; e.mask = eu_mask; e.data = eu_data;
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(e);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk_i) begin
    #2;
    begin
      automatic bit exp_rf = (q.size() > 0) && (q[0].mask != 4'd0);
      automatic bit exp_wb = (q.size() > 0) && ((q[0].mask == 4'd0) || rf_ready);
      check("model_ready", eu_ready, (q.size() < DEPTH));
      check("model_occupancy", occ, q.size());
      check("model_rf_valid", rf_valid, exp_rf);
      if (exp_rf) begin
        check("model_rf_wid", rf_wid, q[0].iid[2:0]);
        check("model_rf_dst", rf_dst, q[0].dst);
        check("model_rf_mask", rf_mask, q[0].mask);
        check("model_rf_data", rf_data, q[0].data);
      end
      check("model_wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        check("model_wb_wid", wb_wid, q[0].iid[2:0]);
        check("model_wb_tag", wb_tag, q[0].iid[5:3]);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] tag, input logic [2:0] wid,
                       input logic [7:0] dst, input logic [3:0] mask,
                       input logic [127:0] data, input logic rfr);
    @(negedge clk_i);
    eu_valid = v;
    eu_tag   = {tag, wid};
    eu_dst   = dst;
    eu_mask  = mask;
    eu_data  = data;
    rf_ready = rfr;
    #3;
  endtask

  task automatic idle(input logic rfr);
    drive(1'b0, 3'd0, 3'd0, 8'd0, 4'd0, 128'd0, rfr);
  endtask

  initial begin
    // Reset state
    idle(1'b0);
    check("rst_ready", eu_ready, 1'b1);
    check("rst_occ", occ, 2'd0);
    check("rst_rf_valid", rf_valid, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    rst_ni = 1'b1;
    idle(1'b0);

    // Single full-mask result with RF ready
    drive(1'b1, 3'd3, 3'd5, 8'd7, 4'b1111, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 1'b1);
    check("single_no_fallthrough", rf_valid, 1'b0);
    idle(1'b1);
    check("single_rf_valid", rf_valid, 1'b1);
    check("single_rf_wid", rf_wid, 3'd5);
    check("single_rf_dst", rf_dst, 8'd7);
    check("single_wb_valid", wb_valid, 1'b1);
    check("single_wb_wid", wb_wid, 3'd5);
    check("single_wb_tag", wb_tag, 3'd3);
    idle(1'b0);
    check("single_drained", occ, 2'd0);

    // Back-pressure: two results held, then released in order
    drive(1'b1, 3'd1, 3'd2, 8'd10, 4'b1111, 128'hAAAA_0001, 1'b0);
    drive(1'b1, 3'd2, 3'd6, 8'd11, 4'b1111, 128'hBBBB_0002, 1'b0);
    check("bp_occ1", occ, 2'd1);
    check("bp_rf_dst1", rf_dst, 8'd10);
    idle(1'b0);
    check("bp_full_ready", eu_ready, 1'b0);
    check("bp_full_occ", occ, 2'd2);
    check("bp_held_dst", rf_dst, 8'd10);
    check("bp_held_data", rf_data, 128'hAAAA_0001);
    check("bp_no_wb", wb_valid, 1'b0);
    idle(1'b1);
    check("bp_wb1", wb_valid, 1'b1);
    check("bp_wb1_tag", wb_tag, 3'd1);
    check("bp_wb1_wid", wb_wid, 3'd2);
    idle(1'b1);
    check("bp_wb2", wb_valid, 1'b1);
    check("bp_wb2_tag", wb_tag, 3'd2);
    check("bp_wb2_wid", wb_wid, 3'd6);
    check("bp_wb2_dst", rf_dst, 8'd11);
    idle(1'b0);
    check("bp_drained", occ, 2'd0);

    // Empty mask retires without an RF request
    drive(1'b1, 3'd5, 3'd1, 8'd20, 4'b0000, 128'hDEAD, 1'b0);
    idle(1'b0);
    check("zmask_rf_valid", rf_valid, 1'b0);
    check("zmask_wb_valid", wb_valid, 1'b1);
    check("zmask_wb_tag", wb_tag, 3'd5);
    check("zmask_wb_wid", wb_wid, 3'd1);
    idle(1'b0);
    check("zmask_drained", occ, 2'd0);
    check("zmask_single_pulse", wb_valid, 1'b0);

    // Partial mask passes through unchanged
    drive(1'b1, 3'd4, 3'd0, 8'd33, 4'b0101, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0, 1'b1);
    idle(1'b1);
    check("pmask_mask", rf_mask, 4'b0101);
    check("pmask_data", rf_data, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0);
    idle(1'b0);

    // Full FIFO with a concurrent pop: push waits a cycle
    drive(1'b1, 3'd1, 3'd1, 8'd41, 4'b0011, 128'h41, 1'b0);
    drive(1'b1, 3'd2, 3'd2, 8'd42, 4'b0011, 128'h42, 1'b0);
    check("full_occ1", occ, 2'd1);
    drive(1'b1, 3'd3, 3'd3, 8'd43, 4'b0011, 128'h43, 1'b1);
    check("full_ready_low", eu_ready, 1'b0);
    check("full_occ2", occ, 2'd2);
    check("full_pop_tag", wb_tag, 3'd1);
    drive(1'b1, 3'd3, 3'd3, 8'd43, 4'b0011, 128'h43, 1'b0);
    check("full_retry_ready", eu_ready, 1'b1);
    check("full_retry_occ", occ, 2'd1);
    check("full_head_dst", rf_dst, 8'd42);
    idle(1'b1);
    check("full_after_occ", occ, 2'd2);
    check("full_wb_d_tag", wb_tag, 3'd2);
    idle(1'b1);
    check("full_wb_e_tag", wb_tag, 3'd3);
    check("full_wb_e_dst", rf_dst, 8'd43);
    idle(1'b0);
    check("full_drained", occ, 2'd0);

    // Reset with two buffered entries
    drive(1'b1, 3'd6, 3'd4, 8'd50, 4'b1111, 128'h50, 1'b0);
    drive(1'b1, 3'd7, 3'd7, 8'd51, 4'b1111, 128'h51, 1'b0);
    idle(1'b0);
    check("prerst_occ", occ, 2'd2);
    rst_ni = 1'b0;
    rf_ready = 1'b1;
    #1;
    check("midrst_occ", occ, 2'd0);
    check("midrst_ready", eu_ready, 1'b1);
    check("midrst_rf_valid", rf_valid, 1'b0);
    check("midrst_wb_valid", wb_valid, 1'b0);
    idle(1'b1);
    rst_ni = 1'b1;
    idle(1'b1);
    check("postrst_occ", occ, 2'd0);
    check("postrst_wb_valid", wb_valid, 1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
